// File: rtl/fb_read_arbiter.sv
// Read-port arbiter for the current_frame framebuffer: driver (port 0) has priority,
// animator (port 1) is protected by a starvation guard, and lock bursts are bounded.
//
// state    | meaning
// ST_IDLE  | no owner; driver wins unless the animator has waited c_max_wait cycles
// ST_LOCK0 | driver holds the port while it keeps requesting with lock
// ST_LOCK1 | animator holds the port while it keeps requesting with lock
module fb_read_arbiter #(
  parameter int c_addr_w   = 10,
  parameter int c_bpc      = 12,
  parameter int c_max_wait = 8,
  parameter int c_max_lock = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req0,
  input  logic                i_lock0,
  input  logic [c_addr_w-1:0] i_addr0,
  output logic                o_gnt0,
  output logic                o_valid0,
  output logic [c_bpc-1:0]    o_rdata0,
  input  logic                i_req1,
  input  logic                i_lock1,
  input  logic [c_addr_w-1:0] i_addr1,
  output logic                o_gnt1,
  output logic                o_valid1,
  output logic [c_bpc-1:0]    o_rdata1,
  output logic [c_addr_w-1:0] o_fb_raddr,
  input  logic [c_bpc-1:0]    i_fb_rdata
);

  localparam int c_wait_w = $clog2(c_max_wait + 1);
  localparam int c_lock_w = $clog2(c_max_lock + 1);
  localparam logic [c_wait_w-1:0] c_wait_top = c_wait_w'(c_max_wait);
  localparam logic [c_lock_w-1:0] c_lock_top = c_lock_w'(c_max_lock);
  localparam logic [c_lock_w-1:0] c_lock_one = c_lock_w'(1);
  localparam bit c_lock_en = (c_max_lock > 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_wait_w-1:0] wait_q, wait_d;
  logic [c_lock_w-1:0] lock_cnt_q, lock_cnt_d;
  logic                valid0_q, valid0_d;
  logic                valid1_q, valid1_d;

  logic                gnt0, gnt1;
  logic                hold0, hold1;
  logic                starve1;
  logic                hold_lock;
  logic [c_lock_w-1:0] lock_inc;

  // Owner keeps the port only while it is still requesting; otherwise fall back to IDLE rules.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    hold0   = (state_q == ST_LOCK0) && i_req0;
    hold1   = (state_q == ST_LOCK1) && i_req1;
    starve1 = i_req1 && (wait_q == c_wait_top);
    if (i_rst_n) begin
      if (hold0)        gnt0 = 1'b1;
      else if (hold1)   gnt1 = 1'b1;
      else if (starve1) gnt1 = 1'b1;
      else if (i_req0)  gnt0 = 1'b1;
      else if (i_req1)  gnt1 = 1'b1;
    end
  end

  always_comb begin
    state_d    = ST_IDLE;
    lock_cnt_d = '0;
    lock_inc   = lock_cnt_q + 1'b1;
    hold_lock  = hold0 ? i_lock0 : i_lock1;
    if (hold0 || hold1) begin
      if (hold_lock && (lock_inc != c_lock_top)) begin
        state_d    = state_q;
        lock_cnt_d = lock_inc;
      end
    end else if (c_lock_en && ((gnt0 && i_lock0) || (gnt1 && i_lock1))) begin
      state_d    = gnt0 ? ST_LOCK0 : ST_LOCK1;
      lock_cnt_d = c_lock_one;
    end
  end

  // Wait counter saturates so the starvation override stays armed until port 1 is served.
  always_comb begin
    wait_d = wait_q;
    if (gnt1) begin
      wait_d = '0;
    end else if (i_req1 && (wait_q != c_wait_top)) begin
      wait_d = wait_q + 1'b1;
    end
    valid0_d = gnt0;
    valid1_d = gnt1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      lock_cnt_q <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      lock_cnt_q <= lock_cnt_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
    end
  end

  assign o_gnt0     = gnt0;
  assign o_gnt1     = gnt1;
  assign o_fb_raddr = gnt0 ? i_addr0 : (gnt1 ? i_addr1 : '0);
  assign o_valid0   = valid0_q;
  assign o_valid1   = valid1_q;
  assign o_rdata0   = i_fb_rdata;
  assign o_rdata1   = i_fb_rdata;

endmodule
